// File: rtl/hd44780_pkg.sv
// hd44780_pkg: instruction masks, bit positions, DDRAM geometry and the
// address-counter helpers shared by the HD44780 receiver and its DDRAM.
package hd44780_pkg;

    localparam logic [7:0] OP_SET_DDRAM = 8'h80;
    localparam logic [7:0] OP_SET_CGRAM = 8'h40;
    localparam logic [7:0] OP_FUNC_SET  = 8'h20;
    localparam logic [7:0] OP_SHIFT     = 8'h10;
    localparam logic [7:0] OP_DISP_CTRL = 8'h08;
    localparam logic [7:0] OP_ENTRY     = 8'h04;
    localparam logic [7:0] OP_HOME      = 8'h02;
    localparam logic [7:0] OP_CLEAR     = 8'h01;

    localparam int BIT_DL = 4;
    localparam int BIT_N  = 3;
    localparam int BIT_SC = 3;
    localparam int BIT_RL = 2;
    localparam int BIT_D  = 2;
    localparam int BIT_C  = 1;
    localparam int BIT_B  = 0;
    localparam int BIT_ID = 1;

    localparam logic [6:0] LINE0_BASE  = 7'h00;
    localparam logic [6:0] LINE1_BASE  = 7'h40;
    localparam int         LINE_LEN    = 40;
    localparam int         DDRAM_CELLS = 2 * LINE_LEN;
    localparam logic [7:0] CHAR_SPACE  = 8'h20;
    localparam int         BUSY_W      = 16;

    localparam logic [6:0] LINE0_LAST = LINE0_BASE + 7'(LINE_LEN - 1);
    localparam logic [6:0] LINE1_LAST = LINE1_BASE + 7'(LINE_LEN - 1);

    typedef enum logic { NIB_FIRST = 1'b0, NIB_SECOND = 1'b1 } nib_state_t;

    // Wrap is the same in one- and two-line mode: the line ends chain into each other.
    function automatic logic [6:0] ac_next(input logic [6:0] ac, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (ac == LINE0_LAST)      r = LINE1_BASE;
            else if (ac == LINE1_LAST) r = LINE0_BASE;
            else                       r = ac + 7'd1;
        end else begin
            if (ac == LINE0_BASE)      r = LINE1_LAST;
            else if (ac == LINE1_BASE) r = LINE0_LAST;
            else                       r = ac - 7'd1;
        end
        return r;
    endfunction

    function automatic logic addr_in_line(input logic [5:0] col);
        return col < 6'(LINE_LEN);
    endfunction

    function automatic logic [6:0] cell_index(input logic [6:0] a);
        return a[6] ? 7'(LINE_LEN) + {1'b0, a[5:0]} : {1'b0, a[5:0]};
    endfunction

endpackage

// File: rtl/hd44780_ddram.sv
// hd44780_ddram: 80-cell display RAM with a per-cell valid vector so a clear
// takes one cycle; unwritten or out-of-line addresses read as a space.
module hd44780_ddram
    import hd44780_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       clr,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0]             mem [DDRAM_CELLS];
    logic [DDRAM_CELLS-1:0] valid;
    logic [6:0]             wr_idx;
    logic [6:0]             rd_idx;
    logic                   wr_ok;

    assign wr_idx = cell_index(wr_addr);
    assign rd_idx = cell_index(rd_addr);
    assign wr_ok  = wr_en && addr_in_line(wr_addr[5:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      valid <= '0;
        else if (clr)   valid <= '0;
        else if (wr_ok) valid[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_idx] <= wr_data;
    end

    always_comb begin
        rd_data = CHAR_SPACE;
        if (addr_in_line(rd_addr[5:0]) && valid[rd_idx]) rd_data = mem[rd_idx];
    end

endmodule

// File: rtl/hd44780_rx.sv
// hd44780_rx: HD44780 bus receiver; reassembles nibbles, decodes instructions,
// tracks AC/flags and flags violations. DDRAM exists only with HD44780_RX_DDRAM_EN.
module hd44780_rx
    import hd44780_pkg::*;
#(
    parameter int BUSY_LONG  = 2,
    parameter int BUSY_SHORT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       rs,
    input  logic [3:0] data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] cursor,
    output logic       four_bit,
    output logic       two_line,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       cmd_stb,
    output logic       chr_stb,
    output logic [7:0] byte_out,
    output logic       busy,
    output logic       err,
    output nib_state_t nib_state
);

    // cmd_stb/chr_stb are valid-only strobes with no ready: byte_out is valid in
    // exactly the cycle a strobe is high, and the sender must honour busy.
    logic              en_q, rs_q;
    logic [3:0]        data_q, hi_nib, hi_nib_n;
    logic              hi_rs, hi_rs_n;
    nib_state_t        state, state_n;
    logic [6:0]        cursor_n;
    logic              four_bit_n, two_line_n, display_on_n, cursor_on_n, blink_on_n;
    logic              entry_inc_n, cgram_mode, cgram_n;
    logic              cmd_stb_n, chr_stb_n, err_n;
    logic [7:0]        byte_out_n, cur_byte, wr_data;
    logic [BUSY_W-1:0] busy_cnt, busy_cnt_n;
    logic              nib_acc, byte_done, cur_rs, wr_en, clr;
    logic [6:0]        wr_addr;

    assign nib_acc   = en_q & ~en;
    assign busy      = busy_cnt != '0;
    assign nib_state = state;
    assign wr_addr   = cursor;

    always_comb begin
        state_n      = state;
        hi_nib_n     = hi_nib;
        hi_rs_n      = hi_rs;
        cursor_n     = cursor;
        four_bit_n   = four_bit;
        two_line_n   = two_line;
        display_on_n = display_on;
        cursor_on_n  = cursor_on;
        blink_on_n   = blink_on;
        entry_inc_n  = entry_inc;
        cgram_n      = cgram_mode;
        cmd_stb_n    = 1'b0;
        chr_stb_n    = 1'b0;
        byte_out_n   = byte_out;
        busy_cnt_n   = busy ? busy_cnt - BUSY_W'(1) : busy_cnt;
        err_n        = err;
        byte_done    = 1'b0;
        cur_byte     = '0;
        cur_rs       = 1'b0;
        wr_en        = 1'b0;
        wr_data      = '0;
        clr          = 1'b0;

        if (nib_acc) begin
            if (busy) err_n = 1'b1;
            if (!four_bit) begin
                // DB3..0 are not wired, so a lone nibble is the upper half of a byte.
                byte_done = 1'b1;
                cur_byte  = {data_q, 4'h0};
                cur_rs    = rs_q;
                state_n   = NIB_FIRST;
            end else if (state == NIB_FIRST) begin
                hi_nib_n = data_q;
                hi_rs_n  = rs_q;
                state_n  = NIB_SECOND;
            end else begin
                state_n = NIB_FIRST;
                if (hi_rs != rs_q) begin
                    err_n = 1'b1;
                end else begin
                    byte_done = 1'b1;
                    cur_byte  = {hi_nib, data_q};
                    cur_rs    = rs_q;
                end
            end
        end

        if (byte_done) begin
            byte_out_n = cur_byte;
            busy_cnt_n = BUSY_W'(BUSY_SHORT);
            if (cur_rs) begin
                chr_stb_n = 1'b1;
                if (!cgram_mode) begin
                    wr_en    = 1'b1;
                    wr_data  = cur_byte;
                    cursor_n = ac_next(cursor, entry_inc);
                end
            end else begin
                cmd_stb_n = 1'b1;
                if (|(cur_byte & OP_SET_DDRAM)) begin
                    cgram_n = 1'b0;
                    if (addr_in_line(cur_byte[5:0])) begin
                        cursor_n = cur_byte[6:0];
                    end else begin
                        cursor_n = LINE0_BASE;
                        err_n    = 1'b1;
                    end
                end else if (|(cur_byte & OP_SET_CGRAM)) begin
                    cgram_n = 1'b1;
                end else if (|(cur_byte & OP_FUNC_SET)) begin
                    four_bit_n = ~cur_byte[BIT_DL];
                    two_line_n = cur_byte[BIT_N];
                    state_n    = NIB_FIRST;
                end else if (|(cur_byte & OP_SHIFT)) begin
                    if (!cur_byte[BIT_SC]) cursor_n = ac_next(cursor, cur_byte[BIT_RL]);
                end else if (|(cur_byte & OP_DISP_CTRL)) begin
                    display_on_n = cur_byte[BIT_D];
                    cursor_on_n  = cur_byte[BIT_C];
                    blink_on_n   = cur_byte[BIT_B];
                end else if (|(cur_byte & OP_ENTRY)) begin
                    entry_inc_n = cur_byte[BIT_ID];
                end else if (|(cur_byte & OP_HOME)) begin
                    cursor_n   = LINE0_BASE;
                    busy_cnt_n = BUSY_W'(BUSY_LONG);
                end else if (|(cur_byte & OP_CLEAR)) begin
                    clr         = 1'b1;
                    cursor_n    = LINE0_BASE;
                    entry_inc_n = 1'b1;
                    cgram_n     = 1'b0;
                    busy_cnt_n  = BUSY_W'(BUSY_LONG);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q       <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= '0;
            state      <= NIB_FIRST;
            hi_nib     <= '0;
            hi_rs      <= 1'b0;
            cursor     <= LINE0_BASE;
            four_bit   <= 1'b0;
            two_line   <= 1'b0;
            display_on <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            entry_inc  <= 1'b1;
            cgram_mode <= 1'b0;
            cmd_stb    <= 1'b0;
            chr_stb    <= 1'b0;
            byte_out   <= '0;
            busy_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            en_q       <= en;
            rs_q       <= rs;
            data_q     <= data;
            state      <= state_n;
            hi_nib     <= hi_nib_n;
            hi_rs      <= hi_rs_n;
            cursor     <= cursor_n;
            four_bit   <= four_bit_n;
            two_line   <= two_line_n;
            display_on <= display_on_n;
            cursor_on  <= cursor_on_n;
            blink_on   <= blink_on_n;
            entry_inc  <= entry_inc_n;
            cgram_mode <= cgram_n;
            cmd_stb    <= cmd_stb_n;
            chr_stb    <= chr_stb_n;
            byte_out   <= byte_out_n;
            busy_cnt   <= busy_cnt_n;
            err        <= err_n;
        end
    end

`ifdef HD44780_RX_DDRAM_EN
    hd44780_ddram u_ddram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .clr     (clr),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
`else
    logic unused_ddram;
    assign unused_ddram = ^{rd_addr, wr_en, wr_addr, wr_data, clr};
    assign rd_data      = CHAR_SPACE;
`endif

endmodule

// File: tb/tb_hd44780_rx.sv
// tb_hd44780_rx: directed bus traffic into hd44780_rx with a strobe scoreboard
// and direct checks of flags, AC, err and DDRAM read-back.
module tb_hd44780_rx;
    import hd44780_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       rs = 1'b0;
    logic [3:0] data = 4'h0;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] rd_data;
    logic [6:0] cursor;
    logic       four_bit, two_line, display_on, cursor_on, blink_on, entry_inc;
    logic       cmd_stb, chr_stb, busy, err;
    logic [7:0] byte_out;
    nib_state_t nib_state;

    logic [8:0] exp_q[$];
    int         n_vec = 0;
    int         n_miss = 0;
    int         cmd_cnt = 0;
    int         chr_cnt = 0;
    int         cmd_mark, chr_mark;

    hd44780_rx #(.BUSY_LONG(2), .BUSY_SHORT(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .rs         (rs),
        .data       (data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .cursor     (cursor),
        .four_bit   (four_bit),
        .two_line   (two_line),
        .display_on (display_on),
        .cursor_on  (cursor_on),
        .blink_on   (blink_on),
        .entry_inc  (entry_inc),
        .cmd_stb    (cmd_stb),
        .chr_stb    (chr_stb),
        .byte_out   (byte_out),
        .busy       (busy),
        .err        (err),
        .nib_state  (nib_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run still active at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // DDRAM contents are only observable when storage is built.
    function automatic logic [7:0] exp_ram(input logic [7:0] b);
`ifdef HD44780_RX_DDRAM_EN
        return b;
`else
        return (b == 8'h00) ? CHAR_SPACE : CHAR_SPACE;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rd(input string name, input logic [6:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    // driver tasks
    task automatic pulse(input logic r, input logic [3:0] d);
        @(negedge clk);
        rs = r;
        data = d;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_nib8(input logic r, input logic [3:0] d, input int after);
        exp_q.push_back({r, d, 4'h0});
        pulse(r, d);
        gap(after);
    endtask

    task automatic send_byte(input logic r, input logic [7:0] b, input int after);
        exp_q.push_back({r, b});
        pulse(r, b[7:4]);
        gap(1);
        pulse(r, b[3:0]);
        gap(after);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic lcd_init();
        send_nib8(1'b0, 4'h3, 1);
        send_nib8(1'b0, 4'h3, 1);
        send_nib8(1'b0, 4'h3, 1);
        send_nib8(1'b0, 4'h2, 1);
        send_byte(1'b0, 8'h28, 1);
        send_byte(1'b0, 8'h0C, 1);
        send_byte(1'b0, 8'h06, 1);
        send_byte(1'b0, 8'h01, 2);
    endtask

    // scoreboard monitor
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!reset && (cmd_stb || chr_stb)) begin
                n_vec++;
                if (cmd_stb) cmd_cnt++;
                if (chr_stb) chr_cnt++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL strobe: got cmd=%0b chr=%0b byte 0x%02h, required no strobe",
                             cmd_stb, chr_stb, byte_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({cmd_stb, chr_stb, byte_out} !== {~e[8], e[8], e[7:0]}) begin
                        n_miss++;
                        $display("FAIL byte: got cmd=%0b chr=%0b 0x%02h, required rs=%0b 0x%02h",
                                 cmd_stb, chr_stb, byte_out, e[8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        // reset values
        gap(3);
        reset = 1'b0;
        gap(1);
        check("rst_cursor", 32'(cursor), 32'h00);
        check("rst_flags", {26'd0, four_bit, two_line, display_on, cursor_on, blink_on, entry_inc}, 32'h01);
        check("rst_err_busy", {30'd0, err, busy}, 32'h0);
        check("rst_byte_out", 32'(byte_out), 32'h00);

        // 8-bit traffic, then asynchronous reset with en high
        send_nib8(1'b0, 4'hC, 1);
        send_nib8(1'b1, 4'h4, 1);
        check("pre_cursor", 32'(cursor), 32'h41);
        check_rd("pre_rd40", 7'h40, exp_ram(8'h40));
        @(negedge clk);
        en = 1'b1;
        rs = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("arst_cursor", 32'(cursor), 32'h00);
        check("arst_strobes", {30'd0, cmd_stb, chr_stb}, 32'h0);
        check("arst_byte_out", 32'(byte_out), 32'h00);
        check("arst_entry_inc", 32'(entry_inc), 32'h1);
        check_rd("arst_rd40", 7'h40, CHAR_SPACE);
        check_rd("arst_rd4b", 7'h4B, CHAR_SPACE);
        @(negedge clk);
        en = 1'b0;
        rs = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // init sequence
        cmd_mark = cmd_cnt;
        lcd_init();
        check("init_cmd_count", 32'(cmd_cnt - cmd_mark), 32'd8);
        check("init_flags", {26'd0, four_bit, two_line, display_on, cursor_on, blink_on, entry_inc}, 32'h39);
        check("init_err", 32'(err), 32'h0);
        check("init_cursor", 32'(cursor), 32'h00);

        // character write on line 2
        chr_mark = chr_cnt;
        send_byte(1'b0, 8'hCB, 1);
        send_byte(1'b1, 8'h31, 1);
        send_byte(1'b1, 8'h32, 1);
        check("chr_cursor", 32'(cursor), 32'h4D);
        check("chr_count", 32'(chr_cnt - chr_mark), 32'd2);
        check("chr_byte_out", 32'(byte_out), 32'h32);
        check_rd("chr_rd4b", 7'h4B, exp_ram(8'h31));
        check_rd("chr_rd4c", 7'h4C, exp_ram(8'h32));

        // AC wrap in both directions
        send_byte(1'b0, 8'hE7, 1);
        check("wrap_set", 32'(cursor), 32'h67);
        send_byte(1'b1, 8'h41, 1);
        check("wrap_inc", 32'(cursor), 32'h00);
        send_byte(1'b0, 8'h04, 1);
        send_byte(1'b1, 8'h42, 1);
        check("wrap_dec", 32'(cursor), 32'h67);
        check("wrap_entry", 32'(entry_inc), 32'h0);
        check_rd("wrap_rd00", 7'h00, exp_ram(8'h42));
        check_rd("wrap_rd67", 7'h67, exp_ram(8'h41));
        check("wrap_err", 32'(err), 32'h0);

        // rs mismatch between nibbles
        pulse(1'b1, 4'h4);
        gap(1);
        pulse(1'b0, 4'h1);
        gap(2);
        check("rsmm_err", 32'(err), 32'h1);
        check("rsmm_cursor", 32'(cursor), 32'h67);
        check_rd("rsmm_rd67", 7'h67, exp_ram(8'h41));
        check("rsmm_state", 32'(nib_state), 32'(NIB_FIRST));

        // busy violation: next pulse right after clear
        do_reset();
        check("rst2_err", 32'(err), 32'h0);
        lcd_init();
        send_byte(1'b0, 8'h01, 0);
        send_byte(1'b0, 8'h80, 1);
        check("busy_err", 32'(err), 32'h1);
        send_byte(1'b1, 8'h41, 2);
        check("busy_err_sticky", 32'(err), 32'h1);
        check("busy_cursor", 32'(cursor), 32'h01);

        // reset after a lone high nibble
        pulse(1'b0, 4'h8);
        gap(1);
        check("mid_state", 32'(nib_state), 32'(NIB_SECOND));
        do_reset();
        check("mid_rst_state", 32'(nib_state), 32'(NIB_FIRST));
        check("mid_rst_4bit", 32'(four_bit), 32'h0);
        lcd_init();
        send_byte(1'b0, 8'h80, 1);
        send_byte(1'b1, 8'h48, 2);
        check("mid_cursor", 32'(cursor), 32'h01);
        check("mid_err", 32'(err), 32'h0);
        check_rd("mid_rd00", 7'h00, exp_ram(8'h48));

        gap(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
